// File: rtl/jtag_pkg.sv
// Shared types and constants for the RISC-V JTAG debug transport module:
// TAP states, IR opcodes, scan-register widths and DR selection decode.
package jtag_pkg;

  localparam int unsigned IR_W    = 5;
  localparam int unsigned DTMCS_W = 32;
  localparam int unsigned DMI_W   = 66;
  localparam int unsigned DMI_AW  = 32;
  localparam int unsigned DMI_DW  = 32;

  localparam logic [IR_W-1:0] IR_IDCODE = 5'h01;
  localparam logic [IR_W-1:0] IR_DTMCS  = 5'h10;
  localparam logic [IR_W-1:0] IR_DMI    = 5'h11;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;
  localparam logic [1:0] DMI_ST_BUSY  = 2'd3;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_e;

  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI} dr_sel_e;

  function automatic dr_sel_e decode_ir(input logic [IR_W-1:0] ir);
    case (ir)
      IR_IDCODE: return SEL_IDCODE;
      IR_DTMCS:  return SEL_DTMCS;
      IR_DMI:    return SEL_DMI;
      default:   return SEL_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller: 16-state FSM driven by TMS, state exported.
module jtag_tap
  import jtag_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tms,
  output logic [3:0] o_state
);

  tap_state_e r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= TEST_LOGIC_RESET;
    end else begin
      case (r_state)
        TEST_LOGIC_RESET: r_state <= i_tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    r_state <= i_tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:        r_state <= i_tms ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       r_state <= i_tms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR:         r_state <= i_tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR:         r_state <= i_tms ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         r_state <= i_tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR:         r_state <= i_tms ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        r_state <= i_tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:        r_state <= i_tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       r_state <= i_tms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR:         r_state <= i_tms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR:         r_state <= i_tms ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         r_state <= i_tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR:         r_state <= i_tms ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:        r_state <= i_tms ? SELECT_DR : RUN_TEST_IDLE;
        default:          r_state <= TEST_LOGIC_RESET;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/jtag_dtm.sv
// RISC-V debug transport module: IR/DR scan chains behind the TAP and a
// single-outstanding DMI request/ack interface toward the debug module.
module jtag_dtm
  import jtag_pkg::*;
#(
  parameter logic [3:0]  VERSION     = 4'h0,
  parameter logic [15:0] PART_NUMBER = 16'h1,
  parameter logic [10:0] MANUFLD     = 11'h12
) (
  input  logic        jtag_tck_i,
  input  logic        jtag_trst_i,
  input  logic        jtag_tms_i,
  input  logic        jtag_tdi_i,
  output logic        jtag_tdo_o,
  output logic        jtag_tdo_enable_o,
  input  logic        dmi_ack_i,
  input  logic [1:0]  dmi_op_i,
  input  logic [31:0] dmi_rdata_i,
  input  logic        dmi_rdata_valid_i,
  output logic [31:0] dmi_addr_o,
  output logic [31:0] dmi_wdata_o,
  output logic        dmi_we_o,
  output logic        dmi_req_o,
  input  logic [3:0]  dtmcs_version_i,
  input  logic [5:0]  dtmcs_abits_i,
  input  logic [1:0]  dtmcs_dmistat_i,
  input  logic [2:0]  dtmcs_idle_i,
  output logic        dtmcs_dmireset_o,
  output logic        dtmcs_dmihardreset_o
);

  logic [3:0]  w_state_raw;
  tap_state_e  w_state;
  dr_sel_e     w_sel;

  logic [IR_W-1:0]    r_ir, r_ir_sh;
  logic [DMI_W-1:0]   r_dr;
  logic [DMI_AW-1:0]  r_addr;
  logic [DMI_DW-1:0]  r_wdata, r_rdata;
  logic               r_we, r_req;
  logic [1:0]         r_sticky;
  logic               r_dmireset, r_hardreset;

  logic [1:0]         w_dmistat;
  logic [DTMCS_W-1:0] w_dtmcs, w_idcode;
  logic [DMI_W-1:0]   w_dmi_cap;
  logic [1:0]         w_dr_op;

  jtag_tap u_tap (
    .i_clk   (jtag_tck_i),
    .i_rst   (jtag_trst_i),
    .i_tms   (jtag_tms_i),
    .o_state (w_state_raw)
  );

  assign w_state   = tap_state_e'(w_state_raw);
  assign w_sel     = decode_ir(r_ir);
  assign w_dmistat = (r_sticky != '0) ? r_sticky : dtmcs_dmistat_i;
  assign w_dtmcs   = {14'b0, 2'b00, 1'b0, dtmcs_idle_i, w_dmistat,
                      dtmcs_abits_i, dtmcs_version_i};
  assign w_idcode  = {VERSION, PART_NUMBER, MANUFLD, 1'b1};
  assign w_dmi_cap = {r_addr, r_rdata, r_req ? DMI_ST_BUSY : r_sticky};
  assign w_dr_op   = r_dr[1:0];

  always_ff @(posedge jtag_tck_i) begin
    if (jtag_trst_i) begin
      r_ir        <= IR_IDCODE;
      r_ir_sh     <= '0;
      r_dr        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_we        <= 1'b0;
      r_req       <= 1'b0;
      r_sticky    <= '0;
      r_dmireset  <= 1'b0;
      r_hardreset <= 1'b0;
    end else begin
      r_dmireset  <= 1'b0;
      r_hardreset <= 1'b0;

      // Completion is applied first so a same-edge DMI update still sees the
      // old pending request and its busy marking overrides the sticky write.
      if (r_req && dmi_ack_i) begin
        r_req <= 1'b0;
        r_we  <= 1'b0;
        if (dmi_op_i != DMI_OP_NOP) r_sticky <= dmi_op_i;
        if (dmi_rdata_valid_i)      r_rdata  <= dmi_rdata_i;
      end

      case (w_state)
        TEST_LOGIC_RESET: r_ir    <= IR_IDCODE;
        CAPTURE_IR:       r_ir_sh <= 5'b00001;
        SHIFT_IR:         r_ir_sh <= {jtag_tdi_i, r_ir_sh[IR_W-1:1]};
        UPDATE_IR:        r_ir    <= r_ir_sh;
        CAPTURE_DR: begin
          case (w_sel)
            SEL_IDCODE: r_dr <= {34'b0, w_idcode};
            SEL_DTMCS:  r_dr <= {34'b0, w_dtmcs};
            SEL_DMI:    r_dr <= w_dmi_cap;
            default:    r_dr <= '0;
          endcase
        end
        SHIFT_DR: begin
          case (w_sel)
            SEL_DMI:               r_dr <= {jtag_tdi_i, r_dr[DMI_W-1:1]};
            SEL_IDCODE, SEL_DTMCS: r_dr <= {34'b0, jtag_tdi_i, r_dr[DTMCS_W-1:1]};
            default:               r_dr <= {65'b0, jtag_tdi_i};
          endcase
        end
        UPDATE_DR: begin
          if (w_sel == SEL_DTMCS) begin
            if (r_dr[16]) begin
              r_dmireset <= 1'b1;
              r_sticky   <= '0;
            end
            if (r_dr[17]) begin
              r_hardreset <= 1'b1;
              r_sticky    <= '0;
              r_req       <= 1'b0;
              r_we        <= 1'b0;
            end
          end else if (w_sel == SEL_DMI) begin
            if (r_req) begin
              r_sticky <= DMI_ST_BUSY;
            end else if ((w_dr_op == DMI_OP_READ || w_dr_op == DMI_OP_WRITE)
                         && r_sticky == '0) begin
              r_addr  <= r_dr[65:34];
              r_wdata <= r_dr[33:2];
              r_we    <= (w_dr_op == DMI_OP_WRITE);
              r_req   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign jtag_tdo_enable_o    = (w_state == SHIFT_IR) || (w_state == SHIFT_DR);
  assign jtag_tdo_o           = (w_state == SHIFT_IR) ? r_ir_sh[0] :
                                (w_state == SHIFT_DR) ? r_dr[0] : 1'b0;
  assign dmi_addr_o           = r_addr;
  assign dmi_wdata_o          = r_wdata;
  assign dmi_we_o             = r_we;
  assign dmi_req_o            = r_req;
  assign dtmcs_dmireset_o     = r_dmireset;
  assign dtmcs_dmihardreset_o = r_hardreset;

endmodule

// File: tb/tb_jtag_dtm.sv
// Directed bench for jtag_dtm: drives TAP scans through TMS/TDI and compares
// TDO and the DMI/DTMCS side outputs against hand-computed values.
module tb_jtag_dtm;

  logic        tck, trst, tms, tdi, tdo, tdo_en;
  logic        ack, rvalid;
  logic [1:0]  op_i;
  logic [31:0] rdata, addr, wdata;
  logic        we, req, dmireset, hardreset;
  logic [3:0]  ver;
  logic [5:0]  abits;
  logic [1:0]  dstat;
  logic [2:0]  idle;

  int errors = 0;
  int checks = 0;

  jtag_dtm #(.VERSION(4'h0), .PART_NUMBER(16'h1), .MANUFLD(11'h12)) dut (
    .jtag_tck_i           (tck),
    .jtag_trst_i          (trst),
    .jtag_tms_i           (tms),
    .jtag_tdi_i           (tdi),
    .jtag_tdo_o           (tdo),
    .jtag_tdo_enable_o    (tdo_en),
    .dmi_ack_i            (ack),
    .dmi_op_i             (op_i),
    .dmi_rdata_i          (rdata),
    .dmi_rdata_valid_i    (rvalid),
    .dmi_addr_o           (addr),
    .dmi_wdata_o          (wdata),
    .dmi_we_o             (we),
    .dmi_req_o            (req),
    .dtmcs_version_i      (ver),
    .dtmcs_abits_i        (abits),
    .dtmcs_dmistat_i      (dstat),
    .dtmcs_idle_i         (idle),
    .dtmcs_dmireset_o     (dmireset),
    .dtmcs_dmihardreset_o (hardreset)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  task automatic tick(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  // All scans start and end in RUN_TEST_IDLE.
  task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout, output logic en);
    en = 1'b1;
    dout = '0;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 5; i++) begin
      dout[i] = tdo;
      en = en & tdo_en;
      tick(i == 4, din[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  task automatic scan_dr(input logic [65:0] din, input int n, input logic ack_upd,
                         output logic [65:0] dout, output logic en);
    en = 1'b1;
    dout = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      en = en & tdo_en;
      tick(i == n - 1, din[i]);
    end
    tick(1, 0);
    if (ack_upd) begin
      ack = 1'b1;
      op_i = 2'd0;
    end
    tick(0, 0);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    trst = 1'b1;
    tick(1, 0); tick(1, 0);
    checks++; if (req !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL reset_req: req=%b we=%b expected 0 0", req, we); end
    checks++; if (addr !== 32'h0 || wdata !== 32'h0) begin errors++; $display("FAIL reset_addr: addr=%h wdata=%h expected 0 0", addr, wdata); end
    checks++; if (tdo_en !== 1'b0 || tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: en=%b tdo=%b expected 0 0", tdo_en, tdo); end
    checks++; if (dmireset !== 1'b0 || hardreset !== 1'b0) begin errors++; $display("FAIL reset_pulses: %b %b expected 0 0", dmireset, hardreset); end
    trst = 1'b0;
    tick(0, 0);
  endtask

  task automatic test_idcode();
    logic [65:0] d;
    logic en;
    scan_dr(66'h0, 32, 1'b0, d, en);
    checks++; if (d[31:0] !== 32'h00001025) begin errors++; $display("FAIL idcode: got %h expected 00001025", d[31:0]); end
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL idcode_tdo_en: got %b expected 1", en); end
  endtask

  task automatic test_ir_dmi_select();
    logic [4:0] ir;
    logic [65:0] d;
    logic en;
    scan_ir(5'h11, ir, en);
    checks++; if (ir !== 5'b00001) begin errors++; $display("FAIL ir_capture: got %b expected 00001", ir); end
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL ir_tdo_en: got %b expected 1", en); end
    scan_dr({32'h0, 32'h8c, 2'd0}, 66, 1'b0, d, en);
    checks++; if (d !== 66'h0) begin errors++; $display("FAIL dmi_select: got %h expected 0", d); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL dmi_nop_req: got %b expected 0", req); end
  endtask

  task automatic test_dmi_write();
    logic [65:0] d;
    logic en;
    scan_dr({32'h0a, 32'h8c, 2'd2}, 66, 1'b0, d, en);
    checks++; if (d !== 66'h0) begin errors++; $display("FAIL wr_capture: got %h expected 0", d); end
    checks++; if (req !== 1'b1 || we !== 1'b1) begin errors++; $display("FAIL wr_req: req=%b we=%b expected 1 1", req, we); end
    checks++; if (addr !== 32'h0a || wdata !== 32'h8c) begin errors++; $display("FAIL wr_addr: addr=%h wdata=%h expected 0a 8c", addr, wdata); end
    tick(0, 0);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL wr_hold: req=%b expected 1", req); end
    ack = 1'b1; op_i = 2'd0;
    tick(0, 0);
    ack = 1'b0;
    checks++; if (req !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL wr_done: req=%b we=%b expected 0 0", req, we); end
  endtask

  task automatic test_dmi_read();
    logic [65:0] d;
    logic en;
    scan_dr({32'h12, 32'h40, 2'd1}, 66, 1'b0, d, en);
    checks++; if (d !== {32'h0a, 32'h0, 2'd0}) begin errors++; $display("FAIL rd_capture: got %h", d); end
    checks++; if (req !== 1'b1 || we !== 1'b0 || addr !== 32'h12) begin errors++; $display("FAIL rd_req: req=%b we=%b addr=%h expected 1 0 12", req, we, addr); end
    ack = 1'b1; op_i = 2'd0; rdata = 32'h123; rvalid = 1'b1;
    tick(0, 0); tick(0, 0); tick(0, 0);
    ack = 1'b0; rvalid = 1'b0; rdata = 32'hdead;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rd_done: req=%b expected 0", req); end
    scan_dr({32'h12, 32'h8c, 2'd0}, 66, 1'b0, d, en);
    checks++; if (d !== {32'h12, 32'h123, 2'd0}) begin errors++; $display("FAIL rd_data: got %h expected %h", d, {32'h12, 32'h123, 2'd0}); end
    scan_dr({32'h12, 32'h8c, 2'd0}, 66, 1'b0, d, en);
    checks++; if (d !== {32'h12, 32'h123, 2'd0} || req !== 1'b0) begin errors++; $display("FAIL nop_repeat: got %h req=%b", d, req); end
  endtask

  task automatic test_busy_and_dmireset();
    logic [65:0] d;
    logic [4:0] ir;
    logic en;
    scan_dr({32'h20, 32'h55, 2'd2}, 66, 1'b0, d, en);
    checks++; if (req !== 1'b1 || addr !== 32'h20) begin errors++; $display("FAIL busy_first: req=%b addr=%h expected 1 20", req, addr); end
    scan_dr({32'h30, 32'h66, 2'd2}, 66, 1'b0, d, en);
    checks++; if (d !== {32'h20, 32'h123, 2'd3}) begin errors++; $display("FAIL busy_capture: got %h", d); end
    checks++; if (addr !== 32'h20 || wdata !== 32'h55) begin errors++; $display("FAIL busy_ignored: addr=%h wdata=%h expected 20 55", addr, wdata); end
    ack = 1'b1; op_i = 2'd0;
    tick(0, 0);
    ack = 1'b0;
    scan_dr({32'h40, 32'h0, 2'd1}, 66, 1'b0, d, en);
    checks++; if (d !== {32'h20, 32'h123, 2'd3}) begin errors++; $display("FAIL sticky_capture: got %h", d); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL sticky_block: req=%b expected 0", req); end
    scan_ir(5'h10, ir, en);
    scan_dr(66'h0, 32, 1'b0, d, en);
    checks++; if (d[31:0] !== 32'h00005c71) begin errors++; $display("FAIL dtmcs_sticky: got %h expected 00005c71", d[31:0]); end
    scan_dr(66'h10000, 32, 1'b0, d, en);
    checks++; if (dmireset !== 1'b1 || hardreset !== 1'b0) begin errors++; $display("FAIL dmireset_pulse: %b %b expected 1 0", dmireset, hardreset); end
    tick(0, 0);
    checks++; if (dmireset !== 1'b0) begin errors++; $display("FAIL dmireset_one: got %b expected 0", dmireset); end
    scan_dr(66'h0, 32, 1'b0, d, en);
    checks++; if (d[31:0] !== 32'h00005871) begin errors++; $display("FAIL dtmcs_cleared: got %h expected 00005871", d[31:0]); end
    scan_ir(5'h11, ir, en);
    scan_dr({32'h44, 32'h77, 2'd2}, 66, 1'b0, d, en);
    checks++; if (d !== {32'h20, 32'h123, 2'd0}) begin errors++; $display("FAIL after_reset_cap: got %h", d); end
    checks++; if (req !== 1'b1 || addr !== 32'h44 || we !== 1'b1) begin errors++; $display("FAIL after_reset_req: req=%b addr=%h we=%b", req, addr, we); end
  endtask

  task automatic test_hardreset();
    logic [65:0] d;
    logic [4:0] ir;
    logic en;
    scan_ir(5'h10, ir, en);
    scan_dr(66'h20000, 32, 1'b0, d, en);
    checks++; if (d[31:0] !== 32'h00005871) begin errors++; $display("FAIL hard_capture: got %h expected 00005871", d[31:0]); end
    checks++; if (hardreset !== 1'b1 || dmireset !== 1'b0) begin errors++; $display("FAIL hard_pulse: %b %b expected 1 0", hardreset, dmireset); end
    checks++; if (req !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL hard_drop: req=%b we=%b expected 0 0", req, we); end
  endtask

  task automatic test_ack_with_update();
    logic [65:0] d;
    logic [4:0] ir;
    logic en;
    scan_ir(5'h11, ir, en);
    scan_dr({32'h50, 32'h1, 2'd2}, 66, 1'b0, d, en);
    checks++; if (d !== {32'h44, 32'h123, 2'd0} || req !== 1'b1) begin errors++; $display("FAIL same_first: got %h req=%b", d, req); end
    scan_dr({32'h60, 32'h2, 2'd2}, 66, 1'b1, d, en);
    checks++; if (req !== 1'b0 || addr !== 32'h50) begin errors++; $display("FAIL same_reject: req=%b addr=%h expected 0 50", req, addr); end
    scan_dr(66'h0, 66, 1'b0, d, en);
    checks++; if (d !== {32'h50, 32'h123, 2'd3}) begin errors++; $display("FAIL same_busy: got %h", d); end
  endtask

  task automatic test_bypass_and_tlr();
    logic [65:0] d;
    logic [4:0] ir;
    logic en;
    scan_ir(5'h1f, ir, en);
    checks++; if (ir !== 5'b00001) begin errors++; $display("FAIL bypass_ir: got %b expected 00001", ir); end
    scan_dr(66'ha5, 8, 1'b0, d, en);
    checks++; if (d[7:0] !== 8'h4a) begin errors++; $display("FAIL bypass: got %h expected 4a", d[7:0]); end
    for (int i = 0; i < 5; i++) tick(1, 0);
    checks++; if (tdo_en !== 1'b0) begin errors++; $display("FAIL tlr_en: got %b expected 0", tdo_en); end
    tick(0, 0);
    scan_dr(66'h0, 32, 1'b0, d, en);
    checks++; if (d[31:0] !== 32'h00001025) begin errors++; $display("FAIL tlr_idcode: got %h expected 00001025", d[31:0]); end
  endtask

  initial begin
    trst = 1'b1; tms = 1'b1; tdi = 1'b0;
    ack = 1'b0; op_i = 2'd0; rdata = 32'h0; rvalid = 1'b0;
    ver = 4'd1; abits = 6'd7; dstat = 2'd2; idle = 3'd5;
    test_reset();
    test_idcode();
    test_ir_dmi_select();
    test_dmi_write();
    test_dmi_read();
    test_busy_and_dmireset();
    test_hardreset();
    test_ack_with_update();
    test_bypass_and_tlr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_dtm.md
# jtag_dtm

RISC-V debug transport module (DTM) behind a 5-bit-IR IEEE 1149.1 TAP. It decodes TMS into the 16-state TAP controller and shifts IR, IDCODE, BYPASS, DTMCS and the 66-bit DMI register through TDI/TDO. DMI scans are converted into a single-outstanding request/ack transaction toward the debug module. It sits between the chip JTAG pins and the debug module.

## Interface
- VERSION, 4'h0, IDCODE version field
- PART_NUMBER, 16'h1, IDCODE part number
- MANUFLD, 11'h12, IDCODE manufacturer ID
- jtag_tck_i in 1: the only clock; all logic on the rising edge
- jtag_trst_i in 1: reset, synchronous, active-high
- jtag_tms_i, jtag_tdi_i in 1 each: TAP mode select and serial data in
- jtag_tdo_o out 1: serial data out
- jtag_tdo_enable_o out 1: TDO driver enable
- dmi_ack_i in 1: debug module accepted/completed request
- dmi_op_i in 2: response status (0 ok, 2 failed, 3 busy)
- dmi_rdata_i in 32, dmi_rdata_valid_i in 1: read data and its qualifier
- dmi_addr_o out 32, dmi_wdata_o out 32, dmi_we_o out 1, dmi_req_o out 1: request
- dtmcs_version_i in 4, dtmcs_abits_i in 6, dtmcs_dmistat_i in 2, dtmcs_idle_i in 3: DTMCS read-only fields
- dtmcs_dmireset_o out 1, dtmcs_dmihardreset_o out 1: one-cycle pulses

## Operation
- TAP FSM: standard 16 states (TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT/CAPTURE/SHIFT/EXIT1/PAUSE/EXIT2/UPDATE for DR and IR), standard TMS transitions. Reset or five TMS=1 cycles -> TEST_LOGIC_RESET.
- IR: 5 bits, reset value 0x01. CAPTURE_IR loads 5'b00001. UPDATE_IR latches the shifted value.
- Opcodes: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI. All other opcodes, including 0x1F, select BYPASS (1 bit, captures 0).
- IDCODE: {VERSION, PART_NUMBER, MANUFLD, 1'b1}.
- DTMCS: 32 bits, {14'b0, dmihardreset, dmireset, 1'b0, idle, dmistat, abits, version}.
  - dmistat = internal sticky status when nonzero, else dtmcs_dmistat_i. Write bits read as 0.
  - UPDATE_DR with DTMCS selected: bit16 set pulses dtmcs_dmireset_o and clears sticky. Bit17 set pulses dtmcs_dmihardreset_o, clears sticky and drops any pending request.
- DMI: 66 bits, [65:34] addr, [33:2] data, [1:0] op.
  - Capture loads {last addr, read-data latch, status}. Status is 3 if a request is pending, else sticky.
  - UPDATE_DR with op=1 (read) or 2 (write), no pending request and sticky==0: latch addr/wdata, dmi_we_o=(op==2), set dmi_req_o.
  - op=0, or sticky≠0: no request.
  - UPDATE_DR while a request is pending: ignored, sticky=3.
- Completion: first edge with dmi_req_o&&dmi_ack_i clears dmi_req_o and dmi_we_o. A nonzero dmi_op_i is stored into sticky. If dmi_rdata_valid_i is high, dmi_rdata_i is stored into the read-data latch.
- Shift: every SHIFT edge moves the selected register right one bit, TDI into the MSB.
- jtag_tdo_o = LSB of the selected register (IR in SHIFT_IR). jtag_tdo_enable_o = state is SHIFT_IR or SHIFT_DR. When disabled, TDO is 0.

## Timing
- Reset values:
  - FSM: TEST_LOGIC_RESET; IR=0x01.
  - All dmi_*_o, dtmcs_*_o and jtag_tdo_enable_o are 0.
  - Latches and sticky are 0.
- Reset has priority over every event. A pending request is dropped.
- Capture, shift and update take effect on the edge at which the FSM is in that state.
- dmi_req_o and the DTMCS pulses rise on the edge that leaves UPDATE_DR and are visible one cycle after UPDATE_DR.
- dmi_req_o stays high until ack is sampled. Ack held high for several cycles completes only one request.
- Ack in the same cycle as UPDATE_DR: the completion is processed and the new request is rejected (busy).

## Structure
- Package jtag_pkg: TAP state enum, IR opcode constants, register widths (IR 5, DTMCS 32, DMI 66, addr/data 32).
- Sub-module jtag_tap: TAP FSM only, with state output. Register logic stays in the top.

## Test plan
- Reset, TMS=0, scan IR 0x11: TDO returns 5'b00001. A DR scan then selects DMI.
- Reset, scan DR 32 bits with IDCODE: TDO yields 0x00001025.
- DMI write {0x0a,0x8c,2}: dmi_req_o=1, we=1, addr=0x0a, wdata=0x8c. Ack with op 0: req drops next edge.
- DMI read {0x12,0x40,1}: req=1, we=0, addr=0x12. Ack with rdata 0x123 valid. The next DMI scan shifts out {0x12,0x123,0}.
- DMI nop {0x12,0x8c,0}: no req. TDO returns the prior capture.
- Second DMI write while req pending: captured op=3, further requests ignored. DTMCS write bit16: dmireset pulse, sticky cleared, next request accepted.
